// File: rtl/cfg_reader_pkg.sv
// Shared constants and the response record of the configuration reader.
package cfg_reader_pkg;

  // Word offsets (byte address >> 3) inside the 4 KiB window.
  localparam logic [8:0] FEAT_OFF    = 9'h000;
  localparam logic [8:0] SIZE_OFF    = 9'h001;
  localparam logic [8:0] RULE_OFF    = 9'h002;
  localparam logic [8:0] HALT_OFF    = 9'h003;
  localparam logic [8:0] EXC_OFF     = 9'h004;
  localparam logic [8:0] DM_OFF      = 9'h005;
  localparam logic [8:0] EXEC_TBL    = 9'h020;
  localparam logic [8:0] NONIDEM_TBL = 9'h040;
  localparam logic [8:0] CACHED_TBL  = 9'h060;
  // Each table holds 16 base/length pairs.
  localparam logic [8:0] TBL_WORDS   = 9'h020;

  // Bit positions inside the feature word.
  localparam int unsigned FEAT_RVA          = 0;
  localparam int unsigned FEAT_RVB          = 1;
  localparam int unsigned FEAT_RVC          = 2;
  localparam int unsigned FEAT_RVH          = 3;
  localparam int unsigned FEAT_RVV          = 4;
  localparam int unsigned FEAT_RVZCB        = 5;
  localparam int unsigned FEAT_FPU_EN       = 6;
  localparam int unsigned FEAT_CVXIF_EN     = 7;
  localparam int unsigned FEAT_ZICOND_EN    = 8;
  localparam int unsigned FEAT_XF16         = 9;
  localparam int unsigned FEAT_XF16ALT      = 10;
  localparam int unsigned FEAT_XF8          = 11;
  localparam int unsigned FEAT_XFVEC        = 12;
  localparam int unsigned FEAT_RVS          = 13;
  localparam int unsigned FEAT_RVU          = 14;
  localparam int unsigned FEAT_DEBUG_EN     = 15;
  localparam int unsigned FEAT_GTLB_PRESENT = 16;
  localparam int unsigned FEAT_TVAL_EN      = 17;

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } rsp_t;

endpackage

// File: rtl/config_pkg.sv
// Elaborated core configuration record and the presets exposed by the
// configuration reader. Only the fields the reader publishes are modelled.
package config_pkg;

  typedef struct packed {
    logic          RVA;
    logic          RVB;
    logic          RVC;
    logic          RVH;
    logic          RVV;
    logic          RVZCB;
    logic          FpuEn;
    logic          CvxifEn;
    logic          ZiCondExtEn;
    logic          XF16;
    logic          XF16ALT;
    logic          XF8;
    logic          XFVec;
    logic          RVS;
    logic          RVU;
    logic          DebugEn;
    logic          GTlbPresent;
    logic          TvalEn;
    logic [31:0]   NrCommitPorts;
    logic [31:0]   NrLoadBufEntries;
    logic [31:0]   RASDepth;
    logic [31:0]   BTBEntries;
    logic [31:0]   BHTEntries;
    logic [31:0]   NrPMPEntries;
    logic [31:0]   NrNonIdempotentRules;
    logic [31:0]   NrExecuteRegionRules;
    logic [31:0]   NrCachedRegionRules;
    logic [31:0]   MaxOutstandingStores;
    logic [31:0]   AxiIdWidth;
    logic [31:0]   AxiAddrWidth;
    logic [31:0]   AxiDataWidth;
    logic [63:0]   HaltAddress;
    logic [63:0]   ExceptionAddress;
    logic [63:0]   DmBaseAddress;
    logic [1023:0] ExecuteRegionAddrBase;
    logic [1023:0] ExecuteRegionLength;
    logic [1023:0] NonIdempotentAddrBase;
    logic [1023:0] NonIdempotentLength;
    logic [1023:0] CachedRegionAddrBase;
    logic [1023:0] CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  // 64-bit application-class preset with hypervisor. The fourth execute
  // region slot carries a descriptor that is not enabled by the rule count.
  localparam cva6_cfg_t cv64a6_imafdch_sv39 = '{
    RVA: 1'b1, RVB: 1'b1, RVC: 1'b1, RVH: 1'b1, RVV: 1'b0, RVZCB: 1'b1,
    FpuEn: 1'b1, CvxifEn: 1'b1, ZiCondExtEn: 1'b1,
    XF16: 1'b0, XF16ALT: 1'b0, XF8: 1'b0, XFVec: 1'b0,
    RVS: 1'b1, RVU: 1'b1, DebugEn: 1'b1, GTlbPresent: 1'b1, TvalEn: 1'b1,
    NrCommitPorts: 32'd2, NrLoadBufEntries: 32'd2, RASDepth: 32'd2,
    BTBEntries: 32'd32, BHTEntries: 32'd128, NrPMPEntries: 32'd8,
    NrNonIdempotentRules: 32'd2, NrExecuteRegionRules: 32'd3,
    NrCachedRegionRules: 32'd1, MaxOutstandingStores: 32'd7,
    AxiIdWidth: 32'd4, AxiAddrWidth: 32'd64, AxiDataWidth: 32'd64,
    HaltAddress: 64'h800, ExceptionAddress: 64'h808, DmBaseAddress: 64'h0,
    ExecuteRegionAddrBase: {{12{64'h0}}, 64'hFFFF_0000, 64'h8000_0000,
                            64'h0001_0000, 64'h0},
    ExecuteRegionLength:   {{12{64'h0}}, 64'h0000_1000, 64'h4000_0000,
                            64'h0001_0000, 64'h0000_1000},
    NonIdempotentAddrBase: {{13{64'h0}}, 64'h3000_0000, 64'h2000_0000,
                            64'h1000_0000},
    NonIdempotentLength:   {{14{64'h0}}, 64'h1000_0000, 64'h0000_1000},
    CachedRegionAddrBase:  {{15{64'h0}}, 64'h8000_0000},
    CachedRegionLength:    {{15{64'h0}}, 64'h4000_0000}
  };

endpackage

// File: rtl/cfg_reader_rsp_fifo.sv
// Response FIFO: in-order buffer of decoded responses between grant and
// consumption. Head entry is presented combinationally from storage.
module cfg_reader_rsp_fifo
  import cfg_reader_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rsp_t wdata,
  input  logic pop,
  output rsp_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  rsp_t            mem [Depth];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [CntW-1:0] count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= (wptr == PtrW'(Depth - 1)) ? '0 : wptr + PtrW'(1);
      end
      if (do_pop) begin
        rptr <= (rptr == PtrW'(Depth - 1)) ? '0 : rptr + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CntW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CntW'(1);
      end
    end
  end

  // Storage write; contents are meaningless while the entry is not counted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

endmodule

// File: rtl/cva6_cfg_reader.sv
// Read-only discovery window exposing the elaborated core configuration.
// Handshake: a request is accepted on a clock edge where req_i && gnt_o;
// a response is transferred on a clock edge where rvalid_o && rready_i, and
// rdata_o/err_o hold while rvalid_o && !rready_i. gnt_o never depends on
// rready_i, so a slot freed by a pop is offered from the following cycle.
module cva6_cfg_reader
  import cfg_reader_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
  parameter int unsigned           RspDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [11:0] addr_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [63:0] rdata_o,
  output logic        err_o
);

  rsp_t push_rsp;
  rsp_t head_rsp;
  logic fifo_full;
  logic fifo_empty;

  function automatic logic [63:0] feature_word();
    logic [63:0] f;
    f                    = '0;
    f[FEAT_RVA]          = CVA6Cfg.RVA;
    f[FEAT_RVB]          = CVA6Cfg.RVB;
    f[FEAT_RVC]          = CVA6Cfg.RVC;
    f[FEAT_RVH]          = CVA6Cfg.RVH;
    f[FEAT_RVV]          = CVA6Cfg.RVV;
    f[FEAT_RVZCB]        = CVA6Cfg.RVZCB;
    f[FEAT_FPU_EN]       = CVA6Cfg.FpuEn;
    f[FEAT_CVXIF_EN]     = CVA6Cfg.CvxifEn;
    f[FEAT_ZICOND_EN]    = CVA6Cfg.ZiCondExtEn;
    f[FEAT_XF16]         = CVA6Cfg.XF16;
    f[FEAT_XF16ALT]      = CVA6Cfg.XF16ALT;
    f[FEAT_XF8]          = CVA6Cfg.XF8;
    f[FEAT_XFVEC]        = CVA6Cfg.XFVec;
    f[FEAT_RVS]          = CVA6Cfg.RVS;
    f[FEAT_RVU]          = CVA6Cfg.RVU;
    f[FEAT_DEBUG_EN]     = CVA6Cfg.DebugEn;
    f[FEAT_GTLB_PRESENT] = CVA6Cfg.GTlbPresent;
    f[FEAT_TVAL_EN]      = CVA6Cfg.TvalEn;
    return f;
  endfunction

  // Address decode; fields are truncated or zero-extended to their slots.
  function automatic rsp_t decode(input logic [11:0] addr, input logic we);
    rsp_t        rsp;
    logic [8:0]  word;
    logic [3:0]  idx;
    logic [9:0]  lsb;
    logic [31:0] nr;
    logic [63:0] base;
    logic [63:0] len;
    rsp  = '0;
    word = addr[11:3];
    idx  = word[4:1];
    lsb  = {idx, 6'b0};
    nr   = '0;
    base = '0;
    len  = '0;
    if (we || (addr[2:0] != 3'b000)) begin
      rsp.err = 1'b1;
    end else if (word < EXEC_TBL) begin
      case (word)
        FEAT_OFF: rsp.data = feature_word();
        SIZE_OFF: rsp.data = {CVA6Cfg.NrPMPEntries[7:0], CVA6Cfg.BHTEntries[15:0],
                              CVA6Cfg.BTBEntries[15:0], CVA6Cfg.RASDepth[7:0],
                              CVA6Cfg.NrLoadBufEntries[7:0], CVA6Cfg.NrCommitPorts[7:0]};
        RULE_OFF: rsp.data = {CVA6Cfg.AxiDataWidth[15:0], CVA6Cfg.AxiAddrWidth[7:0],
                              CVA6Cfg.AxiIdWidth[7:0], CVA6Cfg.MaxOutstandingStores[7:0],
                              CVA6Cfg.NrCachedRegionRules[7:0],
                              CVA6Cfg.NrExecuteRegionRules[7:0],
                              CVA6Cfg.NrNonIdempotentRules[7:0]};
        HALT_OFF: rsp.data = CVA6Cfg.HaltAddress;
        EXC_OFF:  rsp.data = CVA6Cfg.ExceptionAddress;
        DM_OFF:   rsp.data = CVA6Cfg.DmBaseAddress;
        default:  rsp.err  = 1'b1;
      endcase
    end else if (word < (CACHED_TBL + TBL_WORDS)) begin
      case (word[6:5])
        2'd1: begin
          nr   = CVA6Cfg.NrExecuteRegionRules;
          base = CVA6Cfg.ExecuteRegionAddrBase[lsb +: 64];
          len  = CVA6Cfg.ExecuteRegionLength[lsb +: 64];
        end
        2'd2: begin
          nr   = CVA6Cfg.NrNonIdempotentRules;
          base = CVA6Cfg.NonIdempotentAddrBase[lsb +: 64];
          len  = CVA6Cfg.NonIdempotentLength[lsb +: 64];
        end
        default: begin
          nr   = CVA6Cfg.NrCachedRegionRules;
          base = CVA6Cfg.CachedRegionAddrBase[lsb +: 64];
          len  = CVA6Cfg.CachedRegionLength[lsb +: 64];
        end
      endcase
      // Slots beyond the active rule count read as zero without error.
      if ({28'b0, idx} < nr) begin
        rsp.data = word[0] ? len : base;
      end
    end else begin
      rsp.err = 1'b1;
    end
    return rsp;
  endfunction

  // Accept whenever a slot is free; decode the request in the same cycle.
  always_comb begin
    gnt_o    = req_i && !fifo_full;
    push_rsp = decode(addr_i, we_i);
  end

  cfg_reader_rsp_fifo #(
    .Depth (RspDepth)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (gnt_o),
    .wdata (push_rsp),
    .pop   (rvalid_o && rready_i),
    .rdata (head_rsp),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Response port; data and error are forced low while nothing is buffered.
  always_comb begin
    rvalid_o = !fifo_empty;
    rdata_o  = rvalid_o ? head_rsp.data : '0;
    err_o    = rvalid_o && head_rsp.err;
  end

endmodule
